vend_txn_ctrl: RTL and testbench
================================

// Module: vend_txn_ctrl
// PURPOSE
//  Transaction controller upstream of the inventory stage. Accumulates coin credit, latches a
//  product selection, checks stock and price, then issues a one-cycle dispense pulse (with
//  product index) that the inventory stage consumes to decrement stock. Returns change/refunds
//  to the coin-return mechanism via a valid/ready handshake.
// PARAMETERS
//  CREDIT_W        8     credit/price/change width in cents, unsigned
//  MAX_CREDIT      200   coins that would push credit above this are rejected
//  TIMEOUT_CYCLES  1000  idle cycles in CREDIT before auto-refund (VEND_TIMEOUT_EN only)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         synchronous, active-high reset
//  coin_valid     in   1         one-cycle coin strobe
//  coin_code      in   2         00=5c 01=10c 10=25c 11=100c
//  sel_valid      in   1         one-cycle product-select strobe
//  sel_product    in   2         product index 0..3
//  cancel         in   1         one-cycle refund request
//  stock_level    in   4         stock for `product` from inventory stage, sampled in CHECK
//  change_ready   in   1         coin-return mechanism accepts change
//  product        out  2         latched product index to inventory stage
//  dispense       out  1         one-cycle pulse, consumed by inventory stage
//  credit         out  CREDIT_W  current credit
//  change_valid   out  1         change/refund offer, held until accepted
//  change_amount  out  CREDIT_W  amount offered, stable while change_valid
//  coin_reject    out  1         one-cycle pulse: coin not accepted
//  sold_out       out  1         one-cycle pulse: stock_level==0 at CHECK
//  insufficient   out  1         one-cycle pulse: credit < price at CHECK
//  busy           out  1         high in CHECK, DISPENSE, CHANGE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (product=0, credit=0). Reset mid-transaction drops credit.
//  States IDLE, CREDIT, CHECK, DISPENSE, CHANGE. All outputs registered.
//  IDLE/CREDIT: coin accepted if credit+value <= MAX_CREDIT -> credit+=value, state=CREDIT;
//   else coin_reject next cycle, credit unchanged. sel_valid -> product<=sel_product, go CHECK.
//   Coin+sel same cycle: coin added first; CHECK sees updated credit.
//   cancel has priority over coin and sel (same-cycle coin rejected): credit>0 -> CHANGE,
//   credit==0 -> IDLE, no change offer.
//  CHECK (1 cycle): stock_level==0 -> sold_out, back to CREDIT (IDLE if credit==0);
//   else credit<PRICE[product] -> insufficient, same return rule; else -> DISPENSE.
//  DISPENSE (1 cycle): dispense=1, credit-=PRICE[product]; next CHANGE if remainder>0 else IDLE.
//  CHANGE: change_valid=1, change_amount=credit; on change_valid&&change_ready: credit=0,
//   change_valid=0, IDLE. Stalls indefinitely without change_ready.
//  Coins in CHECK/DISPENSE/CHANGE: rejected (coin_reject). sel/cancel ignored there.
//  Dispense-to-sel latency: sel_valid at cycle N -> CHECK N+1 -> dispense high N+2.
//  No arithmetic wrap: credit bounded by MAX_CREDIT; subtraction only when credit>=price.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: in CREDIT, counter clears on any coin/sel; reaching
//   TIMEOUT_CYCLES-1 idle cycles forces CHANGE (refund of full credit). Counter held 0 elsewhere.
//  Undefined: no counter; credit held indefinitely in CREDIT.
// STRUCTURE
//  Package vend_pkg: coin_code encodings and coin_value() function, PRICE table
//   (P0=25, P1=50, P2=75, P3=100), state enum, CREDIT_W default.
//  Sub-module vend_refund_timer (clear/enable in, expire pulse out), instantiated only under
//   VEND_TIMEOUT_EN. Everything else flat in vend_txn_ctrl.
// TESTING
//  1: coins 25,25, sel=1 -> dispense pulse 2 cycles after sel, product=1, credit 0, IDLE, no change.
//  2: coins 100, sel=0 -> dispense; change_valid amount=75; hold change_ready=0 5 cycles (stable),
//     then ready=1 -> credit 0, IDLE.
//  3: coin 10, sel=3 -> insufficient pulse, credit stays 10, state CREDIT; cancel -> refund 10.
//  4: coin 100, sel=2 with stock_level=0 -> sold_out, no dispense, credit 100 retained.
//  5: credit 200, coin 5 -> coin_reject, credit 200; coin during CHANGE -> coin_reject.
//  6: cancel+coin same cycle with credit 25 -> coin_reject, refund 25; rst during CHANGE -> all 0.
//     With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=16: coin 25 then idle -> refund 25 after 16 cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// coin encodings and values, the product price table and the controller state enum.
package vend_pkg;

    localparam int unsigned VEND_CREDIT_W = 8;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE
    } state_e;

    // Indexed by product number 0..3, values in cents.
    localparam logic [7:0] PRICE [4] = '{8'd25, 8'd50, 8'd75, 8'd100};

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] val;
        case (coin_e'(code))
            COIN_5:   val = 8'd5;
            COIN_10:  val = 8'd10;
            COIN_25:  val = 8'd25;
            COIN_100: val = 8'd100;
            default:  val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_refund_timer.sv
// Idle-cycle counter that raises expire_o after TIMEOUT_CYCLES-1 uninterrupted enabled cycles.
// Only defined when VEND_TIMEOUT_EN is set, since only then does the controller use it.
`ifdef VEND_TIMEOUT_EN
module vend_refund_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d    = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit accumulation, selection check, dispense and change.
// Optional auto-refund on idle credit is enabled by defining VEND_TIMEOUT_EN.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W   = VEND_CREDIT_W,
    parameter int unsigned MAX_CREDIT = 200
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [1:0]          sel_product,
    input  logic                cancel,
    input  logic [3:0]          stock_level,
    input  logic                change_ready,
    output logic [1:0]          product,
    output logic                dispense,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                insufficient,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [1:0]          product_q, product_d;
    logic                dispense_q, dispense_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;
    logic                insufficient_q, insufficient_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price;
    logic                timeout_expire;

`ifdef VEND_TIMEOUT_EN
    vend_refund_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_refund_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (coin_valid | sel_valid | cancel),
        .enable_i (state_q == ST_CREDIT),
        .expire_o (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        product_d       = product_q;
        dispense_d      = 1'b0;
        credit_d        = credit_q;
        change_valid_d  = change_valid_q;
        change_amount_d = change_amount_q;
        coin_reject_d   = 1'b0;
        sold_out_d      = 1'b0;
        insufficient_d  = 1'b0;

        // One extra bit so the MAX_CREDIT comparison can never wrap.
        coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_code));
        price    = CREDIT_W'(PRICE[product_q]);

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d         = ST_CHANGE;
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (coin_valid) begin
                        if (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT)) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = ST_CREDIT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    // A same-cycle coin is already in credit_d, so CHECK sees the sum.
                    if (sel_valid) begin
                        product_d = sel_product;
                        state_d   = ST_CHECK;
                    end else if (timeout_expire) begin
                        state_d         = ST_CHANGE;
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                    end
                end
            end
            ST_CHECK: begin
                coin_reject_d = coin_valid;
                if (stock_level == 4'd0 || credit_q < price) begin
                    sold_out_d     = (stock_level == 4'd0);
                    insufficient_d = (stock_level != 4'd0);
                    state_d        = (credit_q == '0) ? ST_IDLE : ST_CREDIT;
                end else begin
                    dispense_d = 1'b1;
                    credit_d   = credit_q - price;
                    state_d    = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (credit_q != '0) begin
                    state_d         = ST_CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    credit_d        = '0;
                    change_valid_d  = 1'b0;
                    change_amount_d = '0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CHECK) || (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            product_q       <= '0;
            dispense_q      <= 1'b0;
            credit_q        <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            sold_out_q      <= 1'b0;
            insufficient_q  <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            product_q       <= product_d;
            dispense_q      <= dispense_d;
            credit_q        <= credit_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            sold_out_q      <= sold_out_d;
            insufficient_q  <= insufficient_d;
            busy_q          <= busy_d;
        end
    end

    assign product       = product_q;
    assign dispense      = dispense_q;
    assign credit        = credit_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign coin_reject   = coin_reject_q;
    assign sold_out      = sold_out_q;
    assign insufficient  = insufficient_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed scenarios then random traffic, all outputs
// compared every cycle against a transaction-level model of the vending rules.
module tb_vend_txn_ctrl;

    localparam int TO_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       sel_valid;
    logic [1:0] sel_product;
    logic       cancel;
    logic [3:0] stock_level;
    logic       change_ready;
    logic [1:0] product;
    logic       dispense;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       sold_out;
    logic       insufficient;
    logic       busy;

    always #5 clk = ~clk;

    vend_txn_ctrl #(
        .CREDIT_W   (8),
        .MAX_CREDIT (200)
`ifdef VEND_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO_CYCLES)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .sel_valid     (sel_valid),
        .sel_product   (sel_product),
        .cancel        (cancel),
        .stock_level   (stock_level),
        .change_ready  (change_ready),
        .product       (product),
        .dispense      (dispense),
        .credit        (credit),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out),
        .insufficient  (insufficient),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a machine is either open for coins/selection, checking a
    // selection, vending, or holding a refund offer.
    typedef enum {M_OPEN, M_CHECK, M_VEND, M_REFUND} mmode_e;
    int     coin_val [4] = '{5, 10, 25, 100};
    int     prices   [4] = '{25, 50, 75, 100};
    mmode_e m_mode   = M_OPEN;
    int m_credit = 0, m_product = 0, m_cv = 0, m_amt = 0, m_busy = 0, m_idle = 0;
    int m_dispense = 0, m_reject = 0, m_sold = 0, m_insuf = 0;

    task automatic offer_refund();
        m_mode = M_REFUND;
        m_cv   = 1;
        m_amt  = m_credit;
    endtask

    task automatic model_step();
        m_dispense = 0; m_reject = 0; m_sold = 0; m_insuf = 0;
        if (rst) begin
            m_mode = M_OPEN; m_credit = 0; m_product = 0; m_cv = 0; m_amt = 0; m_idle = 0;
        end else begin
            case (m_mode)
                M_OPEN: begin
                    if (cancel) begin
                        m_reject = int'(coin_valid);
                        m_idle   = 0;
                        if (m_credit > 0) offer_refund();
                    end else begin
                        if (coin_valid) begin
                            if (m_credit + coin_val[coin_code] <= 200) m_credit += coin_val[coin_code];
                            else m_reject = 1;
                        end
                        if (sel_valid) begin
                            m_product = int'(sel_product);
                            m_mode    = M_CHECK;
                        end
                        if (coin_valid || sel_valid) m_idle = 0;
                        else if (m_credit > 0) m_idle++;
`ifdef VEND_TIMEOUT_EN
                        if (m_mode == M_OPEN && m_idle == TO_CYCLES) offer_refund();
`endif
                    end
                end
                M_CHECK: begin
                    m_reject = int'(coin_valid);
                    if (stock_level == 0) begin
                        m_sold = 1; m_mode = M_OPEN;
                    end else if (m_credit < prices[m_product]) begin
                        m_insuf = 1; m_mode = M_OPEN;
                    end else begin
                        m_dispense = 1; m_credit -= prices[m_product]; m_mode = M_VEND;
                    end
                end
                M_VEND: begin
                    m_reject = int'(coin_valid);
                    if (m_credit > 0) offer_refund();
                    else m_mode = M_OPEN;
                end
                M_REFUND: begin
                    m_reject = int'(coin_valid);
                    if (change_ready) begin
                        m_credit = 0; m_cv = 0; m_amt = 0; m_mode = M_OPEN;
                    end
                end
                default: m_mode = M_OPEN;
            endcase
            if (m_mode != M_OPEN) m_idle = 0;
        end
        m_busy = int'(m_mode != M_OPEN);
    endtask

    task automatic compare_all();
        check_eq("product",       int'(product),       m_product);
        check_eq("dispense",      int'(dispense),      m_dispense);
        check_eq("credit",        int'(credit),        m_credit);
        check_eq("change_valid",  int'(change_valid),  m_cv);
        check_eq("change_amount", int'(change_amount), m_amt);
        check_eq("coin_reject",   int'(coin_reject),   m_reject);
        check_eq("sold_out",      int'(sold_out),      m_sold);
        check_eq("insufficient",  int'(insufficient),  m_insuf);
        check_eq("busy",          int'(busy),          m_busy);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_strobes();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; rst = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1; coin_code = code;
        cycle();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] p);
        sel_valid = 1'b1; sel_product = p;
        cycle();
        sel_valid = 1'b0;
    endtask

    task automatic take_change();
        change_ready = 1'b1;
        cycle();
        change_ready = 1'b0;
    endtask

    initial begin
        clear_strobes();
        coin_code = 2'd0; sel_product = 2'd0; stock_level = 4'd5; change_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("reset_credit", int'(credit), 0);

        // 1: 25+25, product 1 dispensed two cycles after select
        put_coin(2'd2); put_coin(2'd2);
        select(2'd1);
        check_eq("t1_busy_check", int'(busy), 1);
        cycle();
        check_eq("t1_dispense", int'(dispense), 1);
        check_eq("t1_product", int'(product), 1);
        check_eq("t1_credit", int'(credit), 0);
        cycle();
        check_eq("t1_no_change", int'(change_valid), 0);
        check_eq("t1_idle", int'(busy), 0);

        // 2: 100 for product 0, change 75 held through a stalled return
        put_coin(2'd3);
        select(2'd0);
        cycle();
        check_eq("t2_dispense", int'(dispense), 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_cv_hold", int'(change_valid), 1);
            check_eq("t2_amt_hold", int'(change_amount), 75);
            cycle();
        end
        take_change();
        check_eq("t2_credit_done", int'(credit), 0);
        check_eq("t2_cv_done", int'(change_valid), 0);

        // 3: 10c is short for product 3, then cancel refunds 10
        put_coin(2'd1);
        select(2'd3);
        cycle();
        check_eq("t3_insufficient", int'(insufficient), 1);
        check_eq("t3_credit", int'(credit), 10);
        cancel = 1'b1; cycle(); cancel = 1'b0;
        check_eq("t3_refund", int'(change_amount), 10);
        take_change();

        // 4: sold out keeps credit
        stock_level = 4'd0;
        put_coin(2'd3);
        select(2'd2);
        cycle();
        check_eq("t4_sold_out", int'(sold_out), 1);
        check_eq("t4_no_dispense", int'(dispense), 0);
        check_eq("t4_credit", int'(credit), 100);
        stock_level = 4'd5;
        cancel = 1'b1; cycle(); cancel = 1'b0;
        take_change();

        // 5: credit at 200 rejects a 5c coin; coins rejected while offering change
        put_coin(2'd3); put_coin(2'd3);
        put_coin(2'd0);
        check_eq("t5_reject", int'(coin_reject), 1);
        check_eq("t5_credit", int'(credit), 200);
        cancel = 1'b1; cycle(); cancel = 1'b0;
        put_coin(2'd1);
        check_eq("t5_reject_change", int'(coin_reject), 1);
        check_eq("t5_amt", int'(change_amount), 200);
        take_change();

        // 6: cancel beats a same-cycle coin; reset during change clears all
        put_coin(2'd2);
        cancel = 1'b1; coin_valid = 1'b1; coin_code = 2'd3;
        cycle();
        clear_strobes();
        check_eq("t6_reject", int'(coin_reject), 1);
        check_eq("t6_amt", int'(change_amount), 25);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("t6_rst_credit", int'(credit), 0);
        check_eq("t6_rst_cv", int'(change_valid), 0);
        check_eq("t6_rst_busy", int'(busy), 0);

        // Idle credit: refunded after the timeout when enabled, held otherwise
        put_coin(2'd2);
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < TO_CYCLES - 1; i++) cycle();
        check_eq("to_not_yet", int'(change_valid), 0);
        cycle();
        check_eq("to_refund", int'(change_valid), 1);
        check_eq("to_amt", int'(change_amount), 25);
`else
        for (int i = 0; i < 40; i++) cycle();
        check_eq("hold_credit", int'(credit), 25);
        check_eq("hold_no_refund", int'(change_valid), 0);
        cancel = 1'b1; cycle(); cancel = 1'b0;
`endif
        take_change();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            coin_valid   = ($urandom_range(0, 9) < 3);
            coin_code    = 2'($urandom_range(0, 3));
            sel_valid    = ($urandom_range(0, 9) == 0);
            sel_product  = 2'($urandom_range(0, 3));
            cancel       = ($urandom_range(0, 24) == 0);
            change_ready = ($urandom_range(0, 1) == 1);
            stock_level  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
